mod_counter_scheduler: RTL

- Shares one programmable modulo-N counter (T/JK-style ripple-free synchronous counter datapath) among NREQ requesters.
- Each requester asks for a run of its own modulus; a round-robin arbiter grants the counter, the FSM loads the modulus, runs it to terminal count, and reports completion.
- Sits between the counter-based timing blocks and their clients, replacing per-client dedicated mod-N counters.

---
 rtl/mod_counter_scheduler_pkg.sv | 13 +
 rtl/mod_counter_scheduler_rr_arbiter.sv | 30 +++
 rtl/mod_counter_scheduler.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mod_counter_scheduler_pkg.sv
// Shared constants and state encoding for the modulo-N counter scheduler.
package mod_counter_scheduler_pkg;

  localparam int unsigned NREQ_DEF  = 4;
  localparam int unsigned WIDTH_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mod_counter_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first set req bit searching upward from ptr.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);

  // Rotating priority search; lowest offset from ptr wins.
  always_comb begin
    logic        found;
    int unsigned j;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      j = (32'(ptr) + i) % NREQ;
      if (!found && req[IW'(j)]) begin
        found         = 1'b1;
        gnt[IW'(j)]   = 1'b1;
        idx           = IW'(j);
      end
    end
  end

endmodule

// File: rtl/mod_counter_scheduler.sv
// One programmable modulo-N counter shared round-robin among NREQ requesters.
module mod_counter_scheduler
  import mod_counter_scheduler_pkg::*;
#(
  parameter int unsigned NREQ  = NREQ_DEF,
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] mod_in,
  input  logic                  tick_en,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic [NREQ-1:0]       done
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t            state, state_nx;
  logic [WIDTH-1:0]  mod_reg, mod_nx;
  logic [IW-1:0]     ptr, ptr_nx;
  logic [IW-1:0]     win, win_nx;
  logic [NREQ-1:0]   gnt_nx, done_nx;
  logic              busy_nx, tc_nx;
  logic [WIDTH-1:0]  count_nx;
  logic [NREQ-1:0]   arb_gnt;
  logic [IW-1:0]     arb_idx;
  logic [WIDTH-1:0]  last_cnt;
  logic [IW-1:0]     win_inc;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  // Terminal value: modulus 0 wraps naturally to all-ones (2^WIDTH - 1).
  assign last_cnt = WIDTH'(mod_reg - 1'b1);
  assign win_inc  = (win == IW'(NREQ - 1)) ? '0 : IW'(win + 1'b1);

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      mod_reg <= '0;
      ptr     <= '0;
      win     <= '0;
      gnt     <= '0;
      busy    <= 1'b0;
      count   <= '0;
      tc      <= 1'b0;
      done    <= '0;
    end else begin
      state   <= state_nx;
      mod_reg <= mod_nx;
      ptr     <= ptr_nx;
      win     <= win_nx;
      gnt     <= gnt_nx;
      busy    <= busy_nx;
      count   <= count_nx;
      tc      <= tc_nx;
      done    <= done_nx;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nx = state;
    mod_nx   = mod_reg;
    ptr_nx   = ptr;
    win_nx   = win;
    gnt_nx   = gnt;
    busy_nx  = busy;
    count_nx = count;
    tc_nx    = 1'b0;
    done_nx  = '0;
    unique case (state)
      ST_IDLE: begin
        count_nx = '0;
        gnt_nx   = '0;
        busy_nx  = 1'b0;
        if (|req) begin
          mod_nx   = mod_in[arb_idx*WIDTH +: WIDTH];
          win_nx   = arb_idx;
          gnt_nx   = arb_gnt;
          busy_nx  = 1'b1;
          state_nx = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!req[win]) begin
          // Owner withdrew: abort without completion, still rotate priority.
          state_nx = ST_IDLE;
          gnt_nx   = '0;
          busy_nx  = 1'b0;
          count_nx = '0;
          ptr_nx   = win_inc;
        end else if (tick_en) begin
          if (count == last_cnt) begin
            count_nx     = '0;
            tc_nx        = 1'b1;
            done_nx[win] = 1'b1;
            state_nx     = ST_DONE;
          end else begin
            count_nx = WIDTH'(count + 1'b1);
          end
        end
      end
      ST_DONE: begin
        gnt_nx   = '0;
        busy_nx  = 1'b0;
        ptr_nx   = win_inc;
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
        gnt_nx   = '0;
        busy_nx  = 1'b0;
        count_nx = '0;
      end
    endcase
  end

endmodule
